// File: rtl/kd_node_sorter.sv
// Sort stage for a kd-tree node triple (left, parent, right centers).
// The three centers are ordered by their coordinate on the split axis, using one compare-exchange pass per cycle.
module kd_node_sorter #(
  parameter  int DIM         = 3,
  parameter  int DATA_RANGE  = 255,
  localparam int DIM_SIZE    = $clog2(DATA_RANGE),
  localparam int CENTER_SIZE = DIM * DIM_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CENTER_SIZE-1:0] in_left,
  input  logic [CENTER_SIZE-1:0] in_parent,
  input  logic [CENTER_SIZE-1:0] in_right,
  input  logic [DIM_SIZE-1:0]    in_axis,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CENTER_SIZE-1:0] out_left,
  output logic [CENTER_SIZE-1:0] out_parent,
  output logic [CENTER_SIZE-1:0] out_right,
  output logic [DIM_SIZE-1:0]    out_axis,
  output logic [DIM_SIZE-1:0]    out_child_axis,
  output logic [1:0]             out_swaps,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [CENTER_SIZE-1:0] r_left, r_parent, r_right;
  logic [DIM_SIZE-1:0]    r_axis;
  logic [1:0]             r_swaps;
  logic [1:0]             r_clean;
  logic                   r_phase;
  logic [CENTER_SIZE-1:0] r_outLeft, r_outParent, r_outRight;
  logic [DIM_SIZE-1:0]    r_outAxis, r_outChildAxis;
  logic [1:0]             r_outSwaps;

  logic                   w_accept;
  logic                   w_finish;
  logic                   w_swap;
  logic [DIM_SIZE-1:0]    w_keyLeft, w_keyParent, w_keyRight;
  logic [DIM_SIZE-1:0]    w_effAxis;
  logic [DIM_SIZE-1:0]    w_childAxis;

  assign w_effAxis   = (in_axis >= DIM_SIZE'(DIM)) ? '0 : in_axis;
  assign w_childAxis = (r_axis == DIM_SIZE'(DIM - 1)) ? '0 : r_axis + DIM_SIZE'(1);

  assign w_keyLeft   = r_left  [r_axis*DIM_SIZE +: DIM_SIZE];
  assign w_keyParent = r_parent[r_axis*DIM_SIZE +: DIM_SIZE];
  assign w_keyRight  = r_right [r_axis*DIM_SIZE +: DIM_SIZE];

  // Strict compare keeps equal keys in place, which makes the sort stable.
  assign w_swap = r_phase ? (w_keyParent > w_keyRight) : (w_keyLeft > w_keyParent);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: if (in_valid && !rst) begin
        w_accept    = 1'b1;
        w_nextState = SORT;
      end
      SORT: if (!w_swap && r_clean == 2'd1) begin
        w_finish    = 1'b1;
        w_nextState = DONE;
      end
      DONE: if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);

  // Results are copied to dedicated output registers so they hold through the next sort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_left         <= '0;
      r_parent       <= '0;
      r_right        <= '0;
      r_axis         <= '0;
      r_swaps        <= '0;
      r_clean        <= '0;
      r_phase        <= 1'b0;
      r_outLeft      <= '0;
      r_outParent    <= '0;
      r_outRight     <= '0;
      r_outAxis      <= '0;
      r_outChildAxis <= '0;
      r_outSwaps     <= '0;
    end else begin
      if (w_accept) begin
        r_left   <= in_left;
        r_parent <= in_parent;
        r_right  <= in_right;
        r_axis   <= w_effAxis;
        r_swaps  <= '0;
        r_clean  <= '0;
        r_phase  <= 1'b0;
      end
      if (r_state == SORT) begin
        r_phase <= ~r_phase;
        if (w_swap) begin
          if (r_phase) begin
            r_parent <= r_right;
            r_right  <= r_parent;
          end else begin
            r_left   <= r_parent;
            r_parent <= r_left;
          end
          r_swaps <= r_swaps + 2'd1;
          r_clean <= '0;
        end else begin
          r_clean <= r_clean + 2'd1;
        end
      end
      if (w_finish) begin
        r_outLeft      <= r_left;
        r_outParent    <= r_parent;
        r_outRight     <= r_right;
        r_outAxis      <= r_axis;
        r_outChildAxis <= w_childAxis;
        r_outSwaps     <= r_swaps;
      end
    end
  end

  assign out_left       = r_outLeft;
  assign out_parent     = r_outParent;
  assign out_right      = r_outRight;
  assign out_axis       = r_outAxis;
  assign out_child_axis = r_outChildAxis;
  assign out_swaps      = r_outSwaps;

endmodule

// File: tb/tb_kd_node_sorter.sv
// Self-checking bench for kd_node_sorter: a scoreboard of model results, compared by an output monitor.
module tb_kd_node_sorter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_left, in_parent, in_right;
  logic [7:0]  in_axis;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_left, out_parent, out_right;
  logic [7:0]  out_axis, out_child_axis;
  logic [1:0]  out_swaps;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int readyMode = 1;
  int lastHsEdge = -100;
  int lastAcceptEdge = -100;

  typedef struct {
    logic [23:0] l, p, r;
    logic [7:0]  axis, child;
    logic [1:0]  swaps;
    int          passes;
    int          acceptEdge;
  } exp_t;

  exp_t expQ[$];

  kd_node_sorter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_parent(in_parent), .in_right(in_right), .in_axis(in_axis),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_left(out_left), .out_parent(out_parent), .out_right(out_right),
    .out_axis(out_axis), .out_child_axis(out_child_axis),
    .out_swaps(out_swaps), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Mode 0 holds the output stalled, 1 always accepts, 2 accepts randomly.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cycleCount);
    end
  endtask

  // Reference: stable sort by key, swaps = inversion count, passes from the alternating-pass rule.
  function automatic exp_t refModel(logic [23:0] l, logic [23:0] p, logic [23:0] r, logic [7:0] ax);
    exp_t        e;
    logic [23:0] c[3];
    int          k[3];
    int          a[3];
    int          ks[$];
    logic [23:0] cs[$];
    int          ea, pos, sw, phase, clean, passes, t;
    ea = (ax >= 8'd3) ? 0 : int'(ax);
    c = '{l, p, r};
    for (int i = 0; i < 3; i++) begin
      k[i] = int'((c[i] >> (ea * 8)) & 24'hFF);
      pos = ks.size();
      while (pos > 0 && ks[pos-1] > k[i]) pos--;
      ks.insert(pos, k[i]);
      cs.insert(pos, c[i]);
    end
    sw = 0;
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 3; j++)
        if (k[i] > k[j]) sw++;
    a = k;
    phase = 0; clean = 0; passes = 0;
    while (clean < 2) begin
      if (a[phase] > a[phase+1]) begin
        t = a[phase]; a[phase] = a[phase+1]; a[phase+1] = t;
        clean = 0;
      end else begin
        clean++;
      end
      phase = 1 - phase;
      passes++;
    end
    e.l = cs[0]; e.p = cs[1]; e.r = cs[2];
    e.axis = 8'(ea);
    e.child = 8'((ea + 1) % 3);
    e.swaps = 2'(sw);
    e.passes = passes;
    e.acceptEdge = 0;
    return e;
  endfunction

  exp_t        monExp;
  logic        seenValid = 1'b0;
  logic [23:0] holdL, holdP, holdR;
  logic [1:0]  holdSwaps;

  // Output monitor: pops expected results on each new out_valid and checks holding while stalled.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      seenValid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!seenValid) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedOutput: got out_valid=1 expected no pending result");
          end else begin
            monExp = expQ.pop_front();
            checkOutput("left", 32'(out_left), 32'(monExp.l));
            checkOutput("parent", 32'(out_parent), 32'(monExp.p));
            checkOutput("right", 32'(out_right), 32'(monExp.r));
            checkOutput("axis", 32'(out_axis), 32'(monExp.axis));
            checkOutput("childAxis", 32'(out_child_axis), 32'(monExp.child));
            checkOutput("swaps", 32'(out_swaps), 32'(monExp.swaps));
            checkOutput("latency", 32'(cycleCount - monExp.acceptEdge), 32'(monExp.passes));
          end
          seenValid = 1'b1;
          holdL = out_left; holdP = out_parent; holdR = out_right; holdSwaps = out_swaps;
        end else begin
          checkOutput("holdLeft", 32'(out_left), 32'(holdL));
          checkOutput("holdParent", 32'(out_parent), 32'(holdP));
          checkOutput("holdRight", 32'(out_right), 32'(holdR));
          checkOutput("holdSwaps", 32'(out_swaps), 32'(holdSwaps));
        end
        if (out_ready) begin
          seenValid = 1'b0;
          lastHsEdge = cycleCount + 1;
        end
      end
      if (in_valid && in_ready) begin
        monExp = refModel(in_left, in_parent, in_right, in_axis);
        monExp.acceptEdge = cycleCount + 1;
        expQ.push_back(monExp);
        lastAcceptEdge = cycleCount + 1;
      end
    end
  end

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] p, input logic [23:0] r, input logic [7:0] ax);
    logic sampled;
    int   n;
    @(posedge clk); #1;
    in_left = l; in_parent = p; in_right = r; in_axis = ax;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      sampled = in_ready;
      @(posedge clk);
      if (sampled) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL acceptTimeout: got in_ready=0 for 200 cycles expected acceptance");
        break;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("[TB] FAIL drainTimeout: got busy=%0d pending=%0d expected idle", busy, expQ.size());
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_axis = '0;
    in_left = '0; in_parent = '0; in_right = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 32'(in_ready), 0);
    checkOutput("rstOutValid", 32'(out_valid), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstLeft", 32'(out_left), 0);
    checkOutput("rstSwaps", 32'(out_swaps), 0);
    checkOutput("rstAxis", 32'(out_axis), 0);
    checkOutput("rstChildAxis", 32'(out_child_axis), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("inReadyAfterRst", 32'(in_ready), 1);

    // Directed: sorted, reversed, ties, out-of-range axis.
    readyMode = 1;
    applyStimulus(24'h000010, 24'h000020, 24'h000030, 8'd0);
    waitIdle();
    checkOutput("sortedSwaps", 32'(out_swaps), 0);
    checkOutput("sortedChild", 32'(out_child_axis), 1);
    applyStimulus(24'h003000, 24'h002000, 24'h001000, 8'd1);
    waitIdle();
    checkOutput("revLeft", 32'(out_left), 32'h001000);
    checkOutput("revRight", 32'(out_right), 32'h003000);
    checkOutput("revSwaps", 32'(out_swaps), 3);
    checkOutput("revChild", 32'(out_child_axis), 2);
    applyStimulus(24'h050001, 24'h050002, 24'h050003, 8'd2);
    waitIdle();
    checkOutput("tieLeft", 32'(out_left), 32'h050001);
    checkOutput("tieSwaps", 32'(out_swaps), 0);
    checkOutput("tieChild", 32'(out_child_axis), 0);
    applyStimulus(24'h000030, 24'h000020, 24'h000010, 8'd3);
    waitIdle();
    checkOutput("axis3Axis", 32'(out_axis), 0);
    checkOutput("axis3Child", 32'(out_child_axis), 1);

    // Backpressure with an ignored input pulse.
    readyMode = 0;
    applyStimulus(24'h000001, 24'h000003, 24'h000002, 8'd0);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checkOutput("bpValidRise", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 4);
      in_left = 24'h0000AA; in_parent = 24'h000011; in_right = 24'h000055; in_axis = 8'd0;
      @(negedge clk);
      checkOutput("bpInReady", 32'(in_ready), 0);
      checkOutput("bpValidHeld", 32'(out_valid), 1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    readyMode = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_ready && n < 10);
    @(negedge clk);
    checkOutput("bpReleaseValid", 32'(out_valid), 0);
    checkOutput("bpReleaseInReady", 32'(in_ready), 1);
    checkOutput("bpNoPending", 32'(expQ.size()), 0);

    // Reset on the second SORT cycle aborts the triple.
    applyStimulus(24'h003000, 24'h002000, 24'h001000, 8'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abortValid", 32'(out_valid), 0);
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortLeft", 32'(out_left), 0);
    checkOutput("abortSwaps", 32'(out_swaps), 0);
    checkOutput("abortChild", 32'(out_child_axis), 0);
    rst = 1'b0;
    applyStimulus(24'h000010, 24'h000020, 24'h000030, 8'd0);
    waitIdle();
    checkOutput("postAbortSwaps", 32'(out_swaps), 0);
    checkOutput("postAbortParent", 32'(out_parent), 32'h000020);

    // Back-to-back: second accepted one cycle after the first handshake.
    applyStimulus(24'h000300, 24'h000100, 24'h000200, 8'd1);
    applyStimulus(24'h020000, 24'h030000, 24'h010000, 8'd2);
    checkOutput("b2bGap", 32'(lastAcceptEdge - lastHsEdge), 1);
    waitIdle();

    // Random triples with small key ranges to exercise ties, random axis and random backpressure.
    readyMode = 2;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(24'($urandom_range(0, 24'h030303)) & 24'h030303,
                    24'($urandom_range(0, 24'h030303)) & 24'h030303,
                    24'($urandom_range(0, 24'h030303)) & 24'h030303,
                    8'($urandom_range(0, 5)));
    end
    readyMode = 1;
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
